// File: rtl/bsg_skid_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bsg_skid_reg                                                  |
// | Purpose  : two-entry valid/ready register slice; all outputs registered  |
// |            except ready_o, which depends only on state and reset_i.      |
// | Option   : BSG_SKID_REG_STALL_CNT_EN adds a saturating stall counter.    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module bsg_skid_reg #(
   parameter int width_p = 16
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic [width_p-1:0] data_i,
   input  logic               v_i,
   output logic               ready_o,
   output logic [width_p-1:0] data_o,
   output logic               v_o,
   input  logic               yumi_i
`ifdef BSG_SKID_REG_STALL_CNT_EN
   ,output logic [15:0]       stall_count_o
`endif
);

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

   logic [1:0]         state_q, state_d;
   logic [width_p-1:0] head_q,  head_d;
   logic [width_p-1:0] skid_q,  skid_d;
   logic               accept;
   logic               consume;

   assign ready_o = !reset_i && (state_q != ST_TWO);
   assign v_o     = (state_q != ST_EMPTY);
   assign data_o  = head_q;
   assign accept  = v_i && ready_o;
   // A yumi_i with nothing held is illegal and simply ignored.
   assign consume = yumi_i && (state_q != ST_EMPTY);

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               head_d  = data_i;
               state_d = ST_ONE;
            end
         end
         ST_ONE: begin
            if (accept && consume) begin
               head_d = data_i;
            end else if (accept) begin
               skid_d  = data_i;
               state_d = ST_TWO;
            end else if (consume) begin
               state_d = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (consume) begin
               head_d  = skid_q;
               state_d = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ST_EMPTY;
         head_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         skid_q  <= skid_d;
      end
   end

`ifdef BSG_SKID_REG_STALL_CNT_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (v_i && !ready_o && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_count_o = stall_cnt_q;
`endif

   a_yumi_legal: assert property (@(posedge clk_i) disable iff (reset_i)
      !(yumi_i && !v_o));

endmodule
`default_nettype wire

// File: tb/tb_bsg_skid_reg.sv
`default_nettype none
// Scoreboard bench for bsg_skid_reg: a word queue with capacity two is the reference.
module tb_bsg_skid_reg;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         reset_i, v_i, yumi_i, ready_o, v_o;
   logic [W-1:0] data_i, data_o;
`ifdef BSG_SKID_REG_STALL_CNT_EN
   logic [15:0]  stall_count_o;
`endif

   always #5 clk = ~clk;

   bsg_skid_reg #(.width_p(W)) dut (
      .clk_i   (clk),
      .reset_i (reset_i),
      .data_i  (data_i),
      .v_i     (v_i),
      .ready_o (ready_o),
      .data_o  (data_o),
      .v_o     (v_o),
      .yumi_i  (yumi_i)
`ifdef BSG_SKID_REG_STALL_CNT_EN
      ,.stall_count_o (stall_count_o)
`endif
   );

   int          checks = 0;
   int          fails  = 0;
   logic [15:0] sb[$];
   int          occ       = 0;
   bit          head_zero = 1'b1;
   int unsigned exp_cnt   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: mid-cycle, compare outputs against the queue model.
   always @(negedge clk) begin
      chk("ready_o", {31'd0, ready_o}, {31'd0, (!reset_i && occ < 2)});
      chk("v_o", {31'd0, v_o}, {31'd0, (occ > 0)});
      if (head_zero) chk("data_o_after_reset", {16'd0, data_o}, 32'd0);
      if (!reset_i && yumi_i && occ > 0) begin
         if (sb.size() == 0) begin
            chk("scoreboard_underflow", 32'd0, 32'd1);
         end else begin
            chk("data_o", {16'd0, data_o}, {16'd0, sb.pop_front()});
         end
      end
`ifdef BSG_SKID_REG_STALL_CNT_EN
      chk("stall_count_o", {16'd0, stall_count_o}, exp_cnt);
`endif
   end

   // One clock of stimulus; the model is advanced at the same edge as the DUT.
   task automatic cyc(input bit r, input bit v, input logic [15:0] d, input bit y);
      bit acc, cons;
      reset_i = r;
      v_i     = v;
      data_i  = d;
      yumi_i  = y && (r || occ > 0);
      @(posedge clk);
      if (r) begin
         occ = 0;
         sb.delete();
         head_zero = 1'b1;
         exp_cnt = 0;
      end else begin
         acc  = v && (occ < 2);
         cons = yumi_i && (occ > 0);
         if (v && occ >= 2 && exp_cnt != 32'hFFFF) exp_cnt++;
         if (acc) begin
            sb.push_back(d);
            head_zero = 1'b0;
         end
         occ = occ + int'(acc) - int'(cons);
      end
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 4; i++) cyc(0, 0, 16'h0, 1);
   endtask

   initial begin
      // reset for two cycles with a pending producer word
      cyc(1, 1, 16'hDEAD, 0);
      cyc(1, 1, 16'hDEAD, 0);
      cyc(0, 0, 16'h0, 0);

      // streaming at full throughput
      for (int i = 1; i <= 16; i++) cyc(0, 1, 16'(i), 1);
      drain();

      // fill, stall, release one slot, then the stalled word enters
      cyc(0, 1, 16'hAAAA, 0);
      cyc(0, 1, 16'h5555, 0);
      for (int i = 0; i < 3; i++) cyc(0, 1, 16'h1234, 0);
      cyc(0, 1, 16'h1234, 1);
      cyc(0, 1, 16'h1234, 0);
      drain();

      // drain to empty from ONE
      cyc(0, 1, 16'hBEEF, 0);
      cyc(0, 0, 16'h0, 1);
      cyc(0, 0, 16'h0, 0);

      // reset while holding two words discards both
      cyc(0, 1, 16'h1111, 0);
      cyc(0, 1, 16'h2222, 0);
      cyc(1, 0, 16'h0, 0);
      cyc(0, 1, 16'h3333, 0);
      cyc(0, 0, 16'h0, 1);
      cyc(0, 0, 16'h0, 0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 199) == 0), $urandom_range(0, 1) == 1,
             16'($urandom), $urandom_range(0, 2) != 0);
      end
      drain();

`ifdef BSG_SKID_REG_STALL_CNT_EN
      cyc(1, 0, 16'h0, 0);
      cyc(0, 1, 16'hA001, 0);
      cyc(0, 1, 16'hA002, 0);
      for (int i = 0; i < 5; i++) cyc(0, 1, 16'hA003, 0);
      chk("stall_five", {16'd0, stall_count_o}, 32'd5);
      for (int i = 0; i < 70000; i++) cyc(0, 1, 16'hA003, 0);
      chk("stall_saturate", {16'd0, stall_count_o}, 32'hFFFF);
      cyc(1, 0, 16'h0, 0);
      chk("stall_reset", {16'd0, stall_count_o}, 32'd0);
`endif

      drain();
      chk("scoreboard_empty", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
`default_nettype wire
